// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer and its control decoder:
// control states, opcodes, R-type function codes and a memory-state helper.
package multicycle_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IF          = 4'd0,
    S_ID          = 4'd1,
    S_R_TYPE_EX   = 4'd2,
    S_I_TYPE_EX   = 4'd3,
    S_BRANCH_EX   = 4'd4,
    S_STORE_EX    = 4'd5,
    S_LOAD_EX     = 4'd6,
    S_STORE_MEM   = 4'd7,
    S_LOAD_MEM    = 4'd8,
    S_R_TYPE_WB   = 4'd9,
    S_I_TYPE_WB   = 4'd10,
    S_LOAD_WB     = 4'd11,
    S_HALT        = 4'd12
  } state_t;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // States that hold a memory access open until mem_ready
  function automatic logic is_mem_state(input state_t s);
    return (s == S_IF) || (s == S_LOAD_MEM) || (s == S_STORE_MEM);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_seq_mem_watchdog.sv
// Memory-wait watchdog: counts consecutive unacknowledged cycles in a memory
// state and flags a timeout on the MEM_TIMEOUT-th one unless mem_ready arrives.
module seq_mem_watchdog
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic in_mem_state,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CNT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

  logic             waiting;
  logic [CNT_W-1:0] cnt_q;

  assign waiting = in_mem_state & ~mem_ready;
  assign timeout = waiting & (cnt_q >= LIMIT);

  // Any acknowledged or non-memory cycle clears, so each access starts from zero
  always_ff @(posedge clk) begin
    if (reset || !waiting) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Next-state controller for the 16-bit multi-cycle CPU (IF/ID/EX/MEM/WB).
// Optional memory-wait timeout fault: define MULTICYCLE_SEQ_MEM_TIMEOUT_EN.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 mem_ready,
  output logic [3:0]           state,
  output logic                 mem_wait,
  output logic                 inst_done,
  output logic [WORD_SIZE-1:0] num_inst,
  output logic                 wwd_valid,
  output logic                 illegal_inst,
  output logic                 is_halted,
  output logic                 mem_error
);

  state_t                state_q;
  state_t                state_d;
  logic                  done_c;
  logic                  wwd_c;
  logic                  illegal_c;
  logic                  wait_c;
  logic                  timeout;
  logic [WORD_SIZE-1:0]  num_q;
  logic                  halted_q;

  always_comb begin
    state_d   = state_q;
    done_c    = 1'b0;
    wwd_c     = 1'b0;
    illegal_c = 1'b0;
    wait_c    = 1'b0;
    case (state_q)
      S_IF: begin
        if (mem_ready) state_d = S_ID;
        else           wait_c  = 1'b1;
      end
      S_ID: begin
        if (opcode == OP_RTYPE) begin
          case (func)
            FN_JPR, FN_JRL: begin
              state_d = S_IF;
              done_c  = 1'b1;
            end
            FN_WWD: begin
              state_d = S_IF;
              done_c  = 1'b1;
              wwd_c   = 1'b1;
            end
            FN_HLT: state_d = S_HALT;
            FN_ADD, FN_SUB, FN_AND, FN_ORR,
            FN_NOT, FN_TCP, FN_SHL, FN_SHR: state_d = S_R_TYPE_EX;
            default: begin
              state_d   = S_IF;
              done_c    = 1'b1;
              illegal_c = 1'b1;
            end
          endcase
        end else begin
          case (opcode)
            OP_JMP, OP_JAL: begin
              state_d = S_IF;
              done_c  = 1'b1;
            end
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: state_d = S_BRANCH_EX;
            OP_ADI, OP_ORI, OP_LHI:         state_d = S_I_TYPE_EX;
            OP_LWD:                         state_d = S_LOAD_EX;
            OP_SWD:                         state_d = S_STORE_EX;
            default: begin
              state_d   = S_IF;
              done_c    = 1'b1;
              illegal_c = 1'b1;
            end
          endcase
        end
      end
      S_R_TYPE_EX: state_d = S_R_TYPE_WB;
      S_I_TYPE_EX: state_d = S_I_TYPE_WB;
      S_LOAD_EX:   state_d = S_LOAD_MEM;
      S_STORE_EX:  state_d = S_STORE_MEM;
      S_R_TYPE_WB, S_I_TYPE_WB, S_LOAD_WB, S_BRANCH_EX: begin
        state_d = S_IF;
        done_c  = 1'b1;
      end
      S_LOAD_MEM: begin
        if (mem_ready) state_d = S_LOAD_WB;
        else           wait_c  = 1'b1;
      end
      S_STORE_MEM: begin
        if (mem_ready) begin
          state_d = S_IF;
          done_c  = 1'b1;
        end else begin
          wait_c = 1'b1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    // A timed-out access abandons the instruction; it is never counted
    if (timeout) begin
      state_d = S_HALT;
      done_c  = 1'b0;
    end
  end

  // ---- state / counter register stage ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IF;
      num_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (done_c) num_q <= num_q + WORD_SIZE'(1);
      if (state_d == S_HALT) halted_q <= 1'b1;
    end
  end

`ifdef MULTICYCLE_SEQ_MEM_TIMEOUT_EN
  logic in_mem;
  logic err_q;

  assign in_mem = is_mem_state(state_q);

  seq_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .reset        (reset),
    .in_mem_state (in_mem),
    .mem_ready    (mem_ready),
    .timeout      (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign mem_error = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^MEM_TIMEOUT;
  assign timeout            = 1'b0;
  assign mem_error          = 1'b0;
`endif

  assign state        = state_q;
  assign num_inst     = num_q;
  assign is_halted    = halted_q;
  assign mem_wait     = wait_c    & ~reset;
  assign inst_done    = done_c    & ~reset;
  assign wwd_valid    = wwd_c     & ~reset;
  assign illegal_inst = illegal_c & ~reset;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed-vector bench for multicycle_sequencer: per-cycle state traces,
// strobes, retired count, halt/reset behaviour and (when enabled) timeout.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        mem_ready;
  logic [3:0]  state;
  logic        mem_wait;
  logic        inst_done;
  logic [15:0] num_inst;
  logic        wwd_valid;
  logic        illegal_inst;
  logic        is_halted;
  logic        mem_error;

  int n_vec   = 0;
  int n_err   = 0;
  int exp_num = 0;

  multicycle_sequencer #(
    .WORD_SIZE   (16),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .func         (func),
    .mem_ready    (mem_ready),
    .state        (state),
    .mem_wait     (mem_wait),
    .inst_done    (inst_done),
    .num_inst     (num_inst),
    .wwd_valid    (wwd_valid),
    .illegal_inst (illegal_inst),
    .is_halted    (is_halted),
    .mem_error    (mem_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive mem_ready in the low phase, then check this cycle
  task automatic cyc(input logic rdy, input logic [3:0] st, input logic done, input string tag);
    @(negedge clk);
    mem_ready = rdy;
    #1;
    chk({tag, "/state"}, 32'(state), 32'(st));
    chk({tag, "/done"}, 32'(inst_done), 32'(done));
    chk({tag, "/wait"}, 32'(mem_wait),
        32'((st == 4'd0 || st == 4'd7 || st == 4'd8) && !rdy && !reset));
    chk({tag, "/halted"}, 32'(is_halted), 32'(st == 4'd12));
  endtask

  // trace: expected state per cycle as nibbles, first cycle most significant
  task automatic do_insn(input string tag, input logic [3:0] op, input logic [5:0] fn,
                         input logic [47:0] trace, input int len, input logic [11:0] rdy,
                         input logic last_done, input logic ill, input logic wwd);
    for (int i = 0; i < len; i++) begin
      logic [3:0] st;
      st = trace[4*(len-1-i) +: 4];
      cyc(rdy[i], st, (i == len - 1) ? last_done : 1'b0, tag);
      chk({tag, "/illegal"}, 32'(illegal_inst), 32'(ill && st == 4'd1));
      chk({tag, "/wwd"}, 32'(wwd_valid), 32'(wwd && st == 4'd1));
      if (i == 0) chk({tag, "/num"}, 32'(num_inst), 32'(exp_num));
      if (st == 4'd0) begin
        opcode = op;
        func   = fn;
      end
    end
    if (last_done) exp_num++;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b0;
    opcode    = 4'd0;
    func      = 6'd0;

    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    chk("rst/wait", 32'(mem_wait), 32'(0));
    chk("rst/done", 32'(inst_done), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst/state", 32'(state), 32'(0));
    chk("rst/num", 32'(num_inst), 32'(0));
    chk("rst/halted", 32'(is_halted), 32'(0));
    chk("rst/merr", 32'(mem_error), 32'(0));

    // Zero-wait stream
    do_insn("adi", 4'd4,  6'd0, 48'h013A,  4, 12'hFFF, 1'b1, 1'b0, 1'b0);
    do_insn("add", 4'd15, 6'd0, 48'h0129,  4, 12'hFFF, 1'b1, 1'b0, 1'b0);
    do_insn("lwd", 4'd7,  6'd0, 48'h0168B, 5, 12'hFFF, 1'b1, 1'b0, 1'b0);
    do_insn("swd", 4'd8,  6'd0, 48'h0157,  4, 12'hFFF, 1'b1, 1'b0, 1'b0);
    // mem_ready low in ID/EX must be ignored
    do_insn("beq", 4'd1,  6'd0, 48'h014,   3, 12'h001, 1'b1, 1'b0, 1'b0);
    do_insn("jmp", 4'd9,  6'd0, 48'h01,    2, 12'hFFF, 1'b1, 1'b0, 1'b0);

    // LWD with 3 IF waits and 2 Load_MEM waits: 10 cycles
    do_insn("lwd_w", 4'd7, 6'd0, 48'h000016888B, 10, 12'h338, 1'b1, 1'b0, 1'b0);

    do_insn("op12", 4'd12, 6'd0,  48'h01, 2, 12'hFFF, 1'b1, 1'b1, 1'b0);
    do_insn("fn40", 4'd15, 6'd40, 48'h01, 2, 12'hFFF, 1'b1, 1'b1, 1'b0);
    do_insn("wwd",  4'd15, 6'd28, 48'h01, 2, 12'hFFF, 1'b1, 1'b0, 1'b1);
    do_insn("hlt",  4'd15, 6'd29, 48'h01, 2, 12'hFFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(i[0], 4'd12, 1'b0, "halt");
    chk("halt/num", 32'(num_inst), 32'(exp_num));
    chk("halt/merr", 32'(mem_error), 32'(0));

    // Reset while halted
    reset = 1'b1;
    cyc(1'b0, 4'd0, 1'b0, "rst_halt");
    chk("rst_halt/num", 32'(num_inst), 32'(0));
    exp_num = 0;
    reset   = 1'b0;
    do_insn("add_r", 4'd15, 6'd1, 48'h0129, 4, 12'hFFF, 1'b1, 1'b0, 1'b0);

    // Reset asserted while stalled in Load_MEM
    do_insn("lwd_p", 4'd7, 6'd0, 48'h0168, 4, 12'h007, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 4'd0, 1'b0, "rst_mem");
    chk("rst_mem/num", 32'(num_inst), 32'(0));
    exp_num = 0;
    reset   = 1'b0;
    do_insn("jal", 4'd10, 6'd0, 48'h01, 2, 12'hFFF, 1'b1, 1'b0, 1'b0);

`ifdef MULTICYCLE_SEQ_MEM_TIMEOUT_EN
    // Four unacknowledged Store_MEM cycles trip the fault
    do_insn("swd_to", 4'd8, 6'd0, 48'h0157777, 7, 12'h007, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd12, 1'b0, "to_halt");
    chk("to/merr", 32'(mem_error), 32'(1));
    chk("to/num", 32'(num_inst), 32'(exp_num));
    reset = 1'b1;
    cyc(1'b0, 4'd0, 1'b0, "to_rst");
    chk("to_rst/merr", 32'(mem_error), 32'(0));
    exp_num = 0;
    reset   = 1'b0;
    // Acknowledge on the limit cycle wins
    do_insn("swd_ok", 4'd8, 6'd0, 48'h0157777, 7, 12'h047, 1'b1, 1'b0, 1'b0);
    chk("ok/merr", 32'(mem_error), 32'(0));
`endif

    @(negedge clk);
    #1;
    chk("final/num", 32'(num_inst), 32'(exp_num));
    chk("final/merr", 32'(mem_error), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
